// File: rtl/rst_seq.sv
// rtl/rst_seq.sv - staged reset sequencer: async assert, synchronized and stretched per-stage release
module rst_seq #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 4,
    parameter int N_STAGES    = 3
) (
    input  logic                i_aclk,
    input  logic                i_rst,
    input  logic                i_sw_rst_req,
    output logic [N_STAGES-1:0] o_rst,
    output logic [N_STAGES-1:0] o_rst_n,
    output logic                o_ready,
    output logic                o_sw_rst_ack
);

    localparam int CMAX = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int IW   = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

    localparam logic [CW-1:0]          HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0]          GAP_LAST  = CW'(STAGE_GAP - 1);
    localparam logic [IW-1:0]          IDX_LAST  = IW'(N_STAGES - 1);
    localparam logic [N_STAGES-1:0]    STAGE_ONE = N_STAGES'(1);
    localparam logic [SYNC_STAGES-2:0] SYNC_ONE  = (SYNC_STAGES - 1)'(1);

    localparam logic [2:0] ST_RESET   = 3'd0;
    localparam logic [2:0] ST_HOLD    = 3'd1;
    localparam logic [2:0] ST_RELEASE = 3'd2;
    localparam logic [2:0] ST_RUN     = 3'd3;
    localparam logic [2:0] ST_SWHOLD  = 3'd4;

    // The RESET->HOLD transition acts as the last synchronizer flop, so the
    // explicit chain is one stage shorter than SYNC_STAGES.
    logic [SYNC_STAGES-2:0] sync_q;
    logic [2:0]             state;
    logic [CW-1:0]          cnt;
    logic [IW-1:0]          idx;
    logic [N_STAGES-1:0]    rst_q;
    logic                   ready_q;
    logic                   ack_q;
    logic                   req_q;
    logic                   req_prev;
    logic                   sw_seq;
    logic                   sw_edge;

    assign sw_edge = req_q & ~req_prev;

    always_ff @(posedge i_aclk or negedge i_rst) begin
        if (!i_rst) begin
            sync_q   <= '0;
            state    <= ST_RESET;
            cnt      <= '0;
            idx      <= '0;
            rst_q    <= '1;
            ready_q  <= 1'b0;
            ack_q    <= 1'b0;
            req_q    <= 1'b0;
            req_prev <= 1'b0;
            sw_seq   <= 1'b0;
        end else begin
            sync_q   <= (sync_q << 1) | SYNC_ONE;
            req_q    <= i_sw_rst_req;
            req_prev <= req_q;
            ack_q    <= 1'b0;
            case (state)
                ST_RESET: begin
                    cnt <= '0;
                    idx <= '0;
                    if (sync_q[SYNC_STAGES-2]) begin
                        state  <= ST_HOLD;
                        sw_seq <= 1'b0;
                    end
                end
                ST_HOLD, ST_SWHOLD: begin
                    if (cnt == HOLD_LAST) begin
                        cnt   <= '0;
                        rst_q <= rst_q & ~STAGE_ONE;
                        if (N_STAGES == 1) begin
                            state   <= ST_RUN;
                            ready_q <= 1'b1;
                            ack_q   <= sw_seq;
                        end else begin
                            state <= ST_RELEASE;
                            idx   <= IW'(1);
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (cnt == GAP_LAST) begin
                        cnt   <= '0;
                        rst_q <= rst_q & ~(STAGE_ONE << idx);
                        if (idx == IDX_LAST) begin
                            state   <= ST_RUN;
                            idx     <= '0;
                            ready_q <= 1'b1;
                            ack_q   <= sw_seq;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    cnt <= '0;
                    idx <= '0;
                    if (sw_edge) begin
                        state   <= ST_SWHOLD;
                        rst_q   <= '1;
                        ready_q <= 1'b0;
                        sw_seq  <= 1'b1;
                    end
                end
                default: begin
                    state   <= ST_RESET;
                    cnt     <= '0;
                    idx     <= '0;
                    rst_q   <= '1;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_rst        = rst_q;
    assign o_rst_n      = ~rst_q;
    assign o_ready      = ready_q;
    assign o_sw_rst_ack = ack_q;

endmodule

// File: tb/tb_rst_seq.sv
// tb/tb_rst_seq.sv - bench for rst_seq: default instance plus a 1-stage/3-sync/1-hold instance
module tb_rst_seq;

    logic       clk = 1'b0;
    logic       rst_in;
    logic       req;
    logic       req1;
    logic [2:0] rst0, rst0_n;
    logic       ready0, ack0;
    logic [0:0] rst1, rst1_n;
    logic       ready1, ack1;

    always #5 clk = ~clk;

    rst_seq dut0 (
        .i_aclk(clk), .i_rst(rst_in), .i_sw_rst_req(req),
        .o_rst(rst0), .o_rst_n(rst0_n), .o_ready(ready0), .o_sw_rst_ack(ack0)
    );

    rst_seq #(.SYNC_STAGES(3), .HOLD_CYCLES(1), .STAGE_GAP(4), .N_STAGES(1)) dut1 (
        .i_aclk(clk), .i_rst(rst_in), .i_sw_rst_req(req1),
        .o_rst(rst1), .o_rst_n(rst1_n), .o_ready(ready1), .o_sw_rst_ack(ack1)
    );

    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    bit glitch = 0;

    // Reference: each instance is either held in reset, sequencing from a known T0, or running.
    int sp[2] = '{2, 3};
    int hp[2] = '{16, 1};
    int gp[2] = '{4, 4};
    int np[2] = '{3, 1};
    int mode[2];
    int since[2];
    int t0[2];
    bit sw[2], r1[2], r2[2], ack_exp[2];

    task automatic model_edge(input int d, input bit rq);
        bit acc;
        if (glitch || !rst_in) begin
            mode[d] = 0; since[d] = 0; sw[d] = 0; r1[d] = 0; r2[d] = 0;
        end
        ack_exp[d] = 0;
        if (rst_in) begin
            acc   = (mode[d] == 2) && r1[d] && !r2[d];
            r2[d] = r1[d];
            r1[d] = rq;
            since[d]++;
            if (mode[d] == 0) begin
                if (since[d] == sp[d]) begin
                    mode[d] = 1; t0[d] = edge_n; sw[d] = 0;
                end
            end else if (acc) begin
                mode[d] = 1; t0[d] = edge_n; sw[d] = 1;
            end
            if (mode[d] == 1 && edge_n == t0[d] + hp[d] + (np[d] - 1) * gp[d]) begin
                mode[d] = 2; ack_exp[d] = sw[d];
            end
        end
    endtask

    function automatic logic [2:0] exp_rst(input int d);
        logic [2:0] v;
        v = 3'b111;
        for (int k = 0; k < np[d]; k++) begin
            if (mode[d] == 2) v[k] = 1'b0;
            else if (mode[d] == 1) v[k] = (edge_n < t0[d] + hp[d] + k * gp[d]);
        end
        return v;
    endfunction

    task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s edge=%0d observed=%b expected=%b", tag, edge_n, got, exp);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        checks++;
        assert (got == exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic check_all();
        logic [2:0] e0, e1;
        e0 = exp_rst(0);
        e1 = exp_rst(1);
        check("rst0", rst0, e0);
        check("rst0_n", rst0_n, ~e0);
        check("ready0", {2'b0, ready0}, {2'b0, mode[0] == 2});
        check("ack0", {2'b0, ack0}, {2'b0, ack_exp[0]});
        check("rst1", {2'b0, rst1}, {2'b0, e1[0]});
        check("rst1_n", {2'b0, rst1_n}, {2'b0, ~e1[0]});
        check("ready1", {2'b0, ready1}, {2'b0, mode[1] == 2});
        check("ack1", {2'b0, ack1}, {2'b0, ack_exp[1]});
    endtask

    task automatic check_async(input string tag);
        check({tag, "_rst0"}, rst0, 3'b111);
        check({tag, "_rst0_n"}, rst0_n, 3'b000);
        check({tag, "_ready0"}, {2'b0, ready0}, 3'b000);
        check({tag, "_ack0"}, {2'b0, ack0}, 3'b000);
        check({tag, "_rst1"}, {2'b0, rst1}, 3'b001);
        check({tag, "_ready1"}, {2'b0, ready1}, 3'b000);
    endtask

    task automatic step();
        @(posedge clk);
        edge_n++;
        model_edge(0, req);
        model_edge(1, req1);
        glitch = 0;
        #1;
        check_all();
    endtask

    task automatic do_glitch();
        #2 rst_in = 1'b0;
        glitch = 1;
        #1 check_async("glitch");
        #1 rst_in = 1'b1;
    endtask

    // Steps from a release just before the next edge; records first ready edges and ack count.
    task automatic measure(input string tag, input int exp_ack);
        int r0, r1at, acks;
        r0 = -1; r1at = -1; acks = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (ready0 && r0 < 0) r0 = i;
            if (ready1 && r1at < 0) r1at = i;
            if (ack0) acks++;
        end
        check_int({tag, "_ready0_edge"}, r0, 26);
        check_int({tag, "_ready1_edge"}, r1at, 4);
        check_int({tag, "_acks"}, acks, exp_ack);
    endtask

    initial begin
        int r0, r1at, acks, ack_at;
        rst_in = 1'b1; req = 1'b0; req1 = 1'b0;
        #1 rst_in = 1'b0;
        #1 check_async("por");
        repeat (3) step();

        // Power-on with a request pulse sampled at E20 (RELEASE) that must be ignored.
        rst_in = 1'b1;
        r0 = -1; r1at = -1; acks = 0;
        for (int i = 1; i <= 60; i++) begin
            step();
            if (ready0 && r0 < 0) r0 = i;
            if (ready1 && r1at < 0) r1at = i;
            if (ack0) acks++;
            req = (i == 19);
        end
        check_int("por_ready0_edge", r0, 26);
        check_int("por_ready1_edge", r1at, 4);
        check_int("por_acks", acks, 0);

        // Software reset, request held high well past completion.
        req = 1'b1;
        acks = 0; ack_at = -1;
        for (int i = 1; i <= 80; i++) begin
            step();
            if (ack0) begin
                acks++;
                if (ack_at < 0) ack_at = i;
            end
            if (i == 2) check("sw_assert", rst0, 3'b111);
            if (i == 75) req = 1'b0;
        end
        check_int("sw_ack_edge", ack_at, 26);
        check_int("sw_acks", acks, 1);

        // Async reset during SWHOLD.
        req = 1'b1;
        repeat (10) step();
        #2 rst_in = 1'b0;
        #1 check_async("mid");
        req = 1'b0;
        repeat (3) step();
        rst_in = 1'b1;
        measure("mid", 0);

        // Sub-cycle glitch while running.
        do_glitch();
        measure("glitch", 0);

        for (int it = 0; it < 25; it++) begin
            case ($urandom_range(0, 4))
                0: repeat ($urandom_range(1, 30)) step();
                1: begin
                    req = 1'b1;
                    repeat ($urandom_range(1, 4)) step();
                    req = 1'b0;
                    repeat ($urandom_range(1, 10)) step();
                end
                2: begin
                    do_glitch();
                    repeat ($urandom_range(1, 40)) step();
                end
                3: begin
                    #2 rst_in = 1'b0;
                    #1 check_async("rand_rst");
                    repeat ($urandom_range(1, 3)) step();
                    rst_in = 1'b1;
                    repeat ($urandom_range(1, 40)) step();
                end
                default: begin
                    req = 1'b1;
                    repeat ($urandom_range(1, 60)) step();
                    req = 1'b0;
                    step();
                end
            endcase
        end
        repeat (40) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rst_seq.md
Name: rst_seq

Overview:
- Reset sequencer: turns the board-level asynchronous active-low reset into staged, synchronously released, active-high resets, one per subsystem.
- Assertion is asynchronous; deassertion is synchronized to i_aclk, stretched, then released stage by stage (stage 0 first).
- Also accepts a synchronous software reset request and acknowledges it once the full sequence completes.

Parameters:
- SYNC_STAGES, 2, depth of the deassertion synchronizer chain (>=2).
- HOLD_CYCLES, 16, cycles reset is held after synchronized deassertion before stage 0 releases (>=1).
- STAGE_GAP, 4, cycles between successive stage releases (>=1).
- N_STAGES, 3, number of reset outputs (>=1).

Ports:
- i_aclk  input  1  system clock.
- i_rst  input  1  asynchronous reset, active-low; clock is i_aclk.
- i_sw_rst_req  input  1  software reset request, synchronous to i_aclk, rising-edge sensitive.
- o_rst  output  N_STAGES  per-stage reset, active-high, registered.
- o_rst_n  output  N_STAGES  bitwise inverse of o_rst.
- o_ready  output  1  high when all stages are released.
- o_sw_rst_ack  output  1  one-cycle pulse when a software reset sequence completes.

Behaviour:
- Reset (i_rst low), asynchronous:
  - o_rst all ones, o_ready=0, o_sw_rst_ack=0.
  - Synchronizer chain, counters and request edge register cleared; FSM=RESET.
- Synchronizer: shifts in 1 each edge while i_rst is high; output reaches 1 on the SYNC_STAGES-th rising edge after i_rst rises. T0 = that edge.
- FSM states:
  - RESET: waits for synchronizer output=1, then -> HOLD.
  - HOLD: counts to HOLD_CYCLES, then -> RELEASE.
  - RELEASE: steps a stage index every STAGE_GAP cycles, then -> RUN.
  - RUN: all stages released, o_ready=1.
  - SWHOLD: software-initiated hold; same counting as HOLD.
- Release timing (power-on):
  - o_rst[k] falls at edge T0 + HOLD_CYCLES + k*STAGE_GAP.
  - o_ready rises on the same edge as o_rst[N_STAGES-1] falls.
  - Released stages stay 0; unreleased stages stay 1.
- Software reset:
  - Accepted only in RUN, on a sampled rising edge: req=1 at edge S, req=0 at S-1.
  - At edge S+1: all o_rst=1 and o_ready=0, synchronously. Sequence restarts from SWHOLD with T0'=S+1, same release timing as power-on.
  - o_sw_rst_ack pulses high for one cycle on the edge where o_ready rises at the end of a software-initiated sequence. It never pulses after a power-on sequence.
- Request boundary cases:
  - Requests (edges or level) in RESET, HOLD, RELEASE or SWHOLD are ignored and not queued.
  - A level held high across the return to RUN does not retrigger; req must go low, then high again.
  - A request held high through power-on is not accepted until it toggles.
- i_rst low mid-sequence, including during RUN or a software reset: immediate asynchronous return to full reset as above. Any pending ack is lost.
- i_rst glitch shorter than one cycle: the outputs still assert asynchronously, and the full sequence reruns from the synchronizer.
- N_STAGES=1: o_ready rises with o_rst[0] release; STAGE_GAP is unused.
- Counters must be sized for max(HOLD_CYCLES, STAGE_GAP) with no wrap-around. Counters are held at 0 in RESET and RUN.

Test Plan:
- Power-on, defaults: i_rst released just before edge E1 -> T0=E2; o_rst[0] falls at E18, o_rst[1] at E22, o_rst[2] at E26; o_ready=1 at E26; o_sw_rst_ack stays 0.
- Software reset: in RUN, req rises and is sampled at edge S=100 -> o_rst=3'b111 and o_ready=0 at E101; stages release at E117, E121, E125; o_sw_rst_ack is a single pulse at E125.
- Ignored request: req pulsed at E20 during power-on RELEASE -> no extra reset cycle, no ack. Req held high from E125 for 50 cycles after the software sequence -> no retrigger.
- Mid-sequence async reset: i_rst low at E110 during SWHOLD -> o_rst=3'b111 immediately, no ack. After release, the power-on timing of scenario 1 repeats, relative to the new edges.
- Parameter sweep: N_STAGES=1, HOLD_CYCLES=1, SYNC_STAGES=3 -> T0 on the 3rd edge after release; o_rst[0] and o_ready change at T0+1.
- Glitch: i_rst low for 2 ns while in RUN -> outputs assert asynchronously, and the full sequence is re-timed from the next synchronized deassertion.
